// File: rtl/sync_mc_ramif_fifo_pkg.sv
// ----------------------------------------------------------------------------
// sync_mc_fifo_pkg
// Shared helpers for the single-clock multi-channel RAM-interfaced FIFO.
//   chw_f       : channel-select width for a given channel count (minimum 1)
//   level_lsb_f : LSB position of one channel's slice in the packed level bus
// ----------------------------------------------------------------------------
package sync_mc_fifo_pkg;

   function automatic int chw_f(input int nch);
      return (nch <= 1) ? 1 : $clog2(nch);
   endfunction

   function automatic int level_lsb_f(input int ch, input int asize);
      return ch * (asize + 1);
   endfunction

endpackage

// File: rtl/sync_mc_ramif_fifo_if.sv
// ----------------------------------------------------------------------------
// sync_mc_ramif_fifo_if
// Producer/consumer handshake of the multi-channel FIFO.
//   winc/wch/wdata        : write request, target channel, data
//   rinc/rch              : read request, source channel
//   rdata/rvalid/rvalid_ch: read data, its valid strobe and channel
// master = traffic generator side, slave = FIFO controller side.
// ----------------------------------------------------------------------------
interface sync_mc_ramif_fifo_if #(
   parameter int DSIZE = 8,
   parameter int CHW   = 1
);
   logic             winc;
   logic [CHW-1:0]   wch;
   logic [DSIZE-1:0] wdata;
   logic             rinc;
   logic [CHW-1:0]   rch;
   logic [DSIZE-1:0] rdata;
   logic             rvalid;
   logic [CHW-1:0]   rvalid_ch;

   modport master (
      output winc, wch, wdata, rinc, rch,
      input  rdata, rvalid, rvalid_ch
   );

   modport slave (
      input  winc, wch, wdata, rinc, rch,
      output rdata, rvalid, rvalid_ch
   );
endinterface

// File: rtl/sync_mc_ramif_fifo_chan_ctrl.sv
// ----------------------------------------------------------------------------
// mc_fifo_chan_ctrl
// Book-keeping for one FIFO channel: pointers, occupancy, status, sticky errors.
//   wr_req/rd_req   : request already decoded for this channel
//   flush           : clears pointers/occupancy, swallows same-cycle requests
//   err_clr         : clears ovf/udf, wins over a same-cycle set
//   wr_acc/rd_acc   : combinational accept strobes (drive the RAM enables)
//   wptr/rptr/cnt   : current pointers and occupancy
//   full..aempty    : status decoded from occupancy
//   ovf/udf         : sticky overflow/underflow flags
// ----------------------------------------------------------------------------
module mc_fifo_chan_ctrl
   import sync_mc_fifo_pkg::*;
#(
   parameter int ASIZE     = 4,
   parameter int AFULL_TH  = 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_req,
   input  logic             rd_req,
   input  logic             flush,
   input  logic             err_clr,
   output logic             wr_acc,
   output logic             rd_acc,
   output logic [ASIZE-1:0] wptr,
   output logic [ASIZE-1:0] rptr,
   output logic [ASIZE:0]   cnt,
   output logic             full,
   output logic             afull,
   output logic             empty,
   output logic             aempty,
   output logic             ovf,
   output logic             udf
);
   localparam int             DEPTH      = 1 << ASIZE;
   localparam logic [ASIZE:0] FULL_LVL   = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] AFULL_LVL  = (ASIZE+1)'(DEPTH - AFULL_TH);
   localparam logic [ASIZE:0] AEMPTY_LVL = (ASIZE+1)'(AEMPTY_TH);

   logic [ASIZE-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
   logic [ASIZE:0]   cnt_d, cnt_q;
   logic             full_d, full_q, afull_d, afull_q;
   logic             empty_d, empty_q, aempty_d, aempty_q;
   logic             ovf_d, ovf_q, udf_d, udf_q;

   // Accept decision, next pointer/occupancy/error state and status decode
   always_comb begin
      wr_acc = wr_req & ~full_q & ~flush;
      rd_acc = rd_req & ~empty_q & ~flush;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      udf_d  = udf_q;

      if (flush) begin
         wptr_d = {ASIZE{1'b0}};
         rptr_d = {ASIZE{1'b0}};
         cnt_d  = {(ASIZE+1){1'b0}};
      end else begin
         if (wr_acc) wptr_d = wptr_q + ASIZE'(1);
         else        wptr_d = wptr_q;
         if (rd_acc) rptr_d = rptr_q + ASIZE'(1);
         else        rptr_d = rptr_q;
         case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + (ASIZE+1)'(1);
            2'b01:   cnt_d = cnt_q - (ASIZE+1)'(1);
            default: cnt_d = cnt_q;
         endcase
      end

      // A request swallowed by flush is not an error
      if (err_clr) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end else begin
         ovf_d = ovf_q | (wr_req & full_q & ~flush);
         udf_d = udf_q | (rd_req & empty_q & ~flush);
      end

      // Status flops are loaded from next occupancy so they track cnt_q exactly
      full_d   = (cnt_d == FULL_LVL);
      empty_d  = (cnt_d == {(ASIZE+1){1'b0}});
      afull_d  = (cnt_d >= AFULL_LVL);
      aempty_d = (cnt_d <= AEMPTY_LVL);
   end

   // Channel state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q   <= {ASIZE{1'b0}};
         rptr_q   <= {ASIZE{1'b0}};
         cnt_q    <= {(ASIZE+1){1'b0}};
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         empty_q  <= 1'b1;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         empty_q  <= empty_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   assign wptr   = wptr_q;
   assign rptr   = rptr_q;
   assign cnt    = cnt_q;
   assign full   = full_q;
   assign afull  = afull_q;
   assign empty  = empty_q;
   assign aempty = aempty_q;
   assign ovf    = ovf_q;
   assign udf    = udf_q;
endmodule

// File: rtl/sync_mc_ramif_fifo.sv
// ----------------------------------------------------------------------------
// sync_mc_ramif_fifo
// NCH independent FIFOs sharing one external simple dual-port RAM; channel c
// owns RAM addresses {c, 0..2^ASIZE-1}.
//   clk, rst_n          : clock, synchronous active-low reset
//   bus (slave)         : write/read requests and read response
//   flush, err_clr      : per-channel flush, global error clear
//   full/afull/empty/aempty/level/ovf/udf : per-channel status
//   o_ram_* / i_ram_rdata : RAM port (read data registered, 1-cycle latency)
// ----------------------------------------------------------------------------
module sync_mc_ramif_fifo
   import sync_mc_fifo_pkg::*;
#(
   parameter int DSIZE     = 8,
   parameter int ASIZE     = 4,
   parameter int NCH       = 2,
   parameter int CHW       = chw_f(NCH),
   parameter int AFULL_TH  = 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   sync_mc_ramif_fifo_if.slave       bus,
   input  logic [NCH-1:0]            flush,
   input  logic                      err_clr,
   output logic [NCH-1:0]            full,
   output logic [NCH-1:0]            afull,
   output logic [NCH-1:0]            empty,
   output logic [NCH-1:0]            aempty,
   output logic [NCH*(ASIZE+1)-1:0]  level,
   output logic [NCH-1:0]            ovf,
   output logic [NCH-1:0]            udf,
   output logic [CHW+ASIZE-1:0]      o_ram_waddr,
   output logic [DSIZE-1:0]          o_ram_wdata,
   output logic                      o_ram_winc,
   output logic [CHW+ASIZE-1:0]      o_ram_raddr,
   output logic                      o_ram_rinc,
   input  logic [DSIZE-1:0]          i_ram_rdata
);
   logic [NCH-1:0]   wr_req_s, rd_req_s, wr_acc_s, rd_acc_s;
   logic [ASIZE-1:0] wptr_s [NCH];
   logic [ASIZE-1:0] rptr_s [NCH];
   logic [ASIZE:0]   cnt_s  [NCH];
   logic [ASIZE-1:0] wptr_sel_s, rptr_sel_s;
   logic             rvalid_d, rvalid_q;
   logic [CHW-1:0]   rvalid_ch_d, rvalid_ch_q;

   // Out-of-range channel numbers match no channel, so they are silently ignored
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign wr_req_s[c] = bus.winc & (bus.wch == CHW'(c));
      assign rd_req_s[c] = bus.rinc & (bus.rch == CHW'(c));

      mc_fifo_chan_ctrl #(
         .ASIZE     (ASIZE),
         .AFULL_TH  (AFULL_TH),
         .AEMPTY_TH (AEMPTY_TH)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_req  (wr_req_s[c]),
         .rd_req  (rd_req_s[c]),
         .flush   (flush[c]),
         .err_clr (err_clr),
         .wr_acc  (wr_acc_s[c]),
         .rd_acc  (rd_acc_s[c]),
         .wptr    (wptr_s[c]),
         .rptr    (rptr_s[c]),
         .cnt     (cnt_s[c]),
         .full    (full[c]),
         .afull   (afull[c]),
         .empty   (empty[c]),
         .aempty  (aempty[c]),
         .ovf     (ovf[c]),
         .udf     (udf[c])
      );

      assign level[level_lsb_f(c, ASIZE) +: ASIZE+1] = cnt_s[c];
   end

   // AND-OR pointer select avoids indexing past NCH for unused channel codes
   always_comb begin
      wptr_sel_s = {ASIZE{1'b0}};
      rptr_sel_s = {ASIZE{1'b0}};
      for (int c = 0; c < NCH; c++) begin
         wptr_sel_s = wptr_sel_s | (wptr_s[c] & {ASIZE{bus.wch == CHW'(c)}});
         rptr_sel_s = rptr_sel_s | (rptr_s[c] & {ASIZE{bus.rch == CHW'(c)}});
      end
   end

   assign o_ram_winc  = |wr_acc_s;
   assign o_ram_waddr = {bus.wch, wptr_sel_s};
   assign o_ram_wdata = bus.wdata;
   assign o_ram_rinc  = |rd_acc_s;
   assign o_ram_raddr = {bus.rch, rptr_sel_s};

   // Read response tag follows the RAM's one-cycle read latency
   always_comb begin
      rvalid_d    = |rd_acc_s;
      rvalid_ch_d = bus.rch;
   end

   // Read response pipeline register; reset discards any in-flight read
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid_q    <= 1'b0;
         rvalid_ch_q <= {CHW{1'b0}};
      end else begin
         rvalid_q    <= rvalid_d;
         rvalid_ch_q <= rvalid_ch_d;
      end
   end

   assign bus.rvalid    = rvalid_q;
   assign bus.rvalid_ch = rvalid_ch_q;
   assign bus.rdata     = i_ram_rdata;
endmodule

// File: tb/tb_sync_mc_ramif_fifo.sv
module tb_sync_mc_ramif_fifo;
   import sync_mc_fifo_pkg::*;

   localparam int DSIZE = 8;
   localparam int ASIZE = 4;
   localparam int NCH   = 2;
   localparam int CHW   = 1;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst_n;
   logic [NCH-1:0]           flush;
   logic                     err_clr;
   logic [NCH-1:0]           full, afull, empty, aempty, ovf, udf;
   logic [NCH*(ASIZE+1)-1:0] level;
   logic [CHW+ASIZE-1:0]     o_ram_waddr, o_ram_raddr;
   logic [DSIZE-1:0]         o_ram_wdata, ram_rdata;
   logic                     o_ram_winc, o_ram_rinc;

   sync_mc_ramif_fifo_if #(.DSIZE(DSIZE), .CHW(CHW)) bus ();

   sync_mc_ramif_fifo #(
      .DSIZE(DSIZE), .ASIZE(ASIZE), .NCH(NCH), .CHW(CHW),
      .AFULL_TH(2), .AEMPTY_TH(2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .flush       (flush),
      .err_clr     (err_clr),
      .full        (full),
      .afull       (afull),
      .empty       (empty),
      .aempty      (aempty),
      .level       (level),
      .ovf         (ovf),
      .udf         (udf),
      .o_ram_waddr (o_ram_waddr),
      .o_ram_wdata (o_ram_wdata),
      .o_ram_winc  (o_ram_winc),
      .o_ram_raddr (o_ram_raddr),
      .o_ram_rinc  (o_ram_rinc),
      .i_ram_rdata (ram_rdata)
   );

   // External RAM: registered read, one cycle latency
   logic [DSIZE-1:0] mem [32];
   always_ff @(posedge clk) begin
      if (o_ram_winc) mem[o_ram_waddr] <= o_ram_wdata;
      if (o_ram_rinc) ram_rdata <= mem[o_ram_raddr];
   end

   // Reference model
   logic [7:0]       mq  [NCH][$];
   logic [ASIZE-1:0] mwp [NCH];
   logic [ASIZE-1:0] mrp [NCH];
   logic [NCH-1:0]   mov, mud;
   logic [8:0]       sb [$];
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_status();
      int n;
      for (int c = 0; c < NCH; c++) begin
         n = mq[c].size();
         chk($sformatf("level%0d", c), 32'(level[c*(ASIZE+1) +: ASIZE+1]), 32'(n));
         chk($sformatf("full%0d", c),   32'(full[c]),   32'(n == DEPTH));
         chk($sformatf("empty%0d", c),  32'(empty[c]),  32'(n == 0));
         chk($sformatf("afull%0d", c),  32'(afull[c]),  32'(n >= DEPTH - 2));
         chk($sformatf("aempty%0d", c), 32'(aempty[c]), 32'(n <= 2));
         chk($sformatf("ovf%0d", c),    32'(ovf[c]),    32'(mov[c]));
         chk($sformatf("udf%0d", c),    32'(udf[c]),    32'(mud[c]));
      end
   endtask

   // One clock cycle of stimulus; called at a falling edge
   task automatic cyc(input logic w, input logic wc, input logic [7:0] wd,
                      input logic r, input logic rc, input logic [1:0] fl,
                      input logic ec);
      logic wacc, racc;
      logic [NCH-1:0] oset, uset;
      logic [8:0] e;
      bus.winc = w; bus.wch = wc; bus.wdata = wd;
      bus.rinc = r; bus.rch = rc; flush = fl; err_clr = ec;
      #1;
      wacc = w && !fl[wc] && (mq[wc].size() < DEPTH);
      racc = r && !fl[rc] && (mq[rc].size() > 0);
      oset = '0; uset = '0;
      if (w && !fl[wc] && mq[wc].size() == DEPTH) oset[wc] = 1'b1;
      if (r && !fl[rc] && mq[rc].size() == 0)     uset[rc] = 1'b1;
      chk("ram_winc", 32'(o_ram_winc), 32'(wacc));
      if (wacc) begin
         chk("ram_waddr", 32'(o_ram_waddr), 32'({wc, mwp[wc]}));
         chk("ram_wdata", 32'(o_ram_wdata), 32'(wd));
      end
      chk("ram_rinc", 32'(o_ram_rinc), 32'(racc));
      if (racc) chk("ram_raddr", 32'(o_ram_raddr), 32'({rc, mrp[rc]}));
      if (racc) begin
         sb.push_back({rc, mq[rc].pop_front()});
         mrp[rc] = mrp[rc] + 4'd1;
      end
      if (wacc) begin
         mq[wc].push_back(wd);
         mwp[wc] = mwp[wc] + 4'd1;
      end
      for (int c = 0; c < NCH; c++) begin
         if (fl[c]) begin
            mq[c].delete();
            mwp[c] = '0;
            mrp[c] = '0;
         end
      end
      if (ec) begin
         mov = '0; mud = '0;
      end else begin
         mov = mov | oset; mud = mud | uset;
      end
      @(posedge clk);
      @(negedge clk);
      chk("rvalid", 32'(bus.rvalid), 32'(racc));
      if (racc) begin
         e = sb.pop_front();
         chk("rdata", 32'(bus.rdata), 32'(e[7:0]));
         chk("rvalid_ch", 32'(bus.rvalid_ch), 32'(e[8]));
      end
      chk_status();
   endtask

   initial begin
      rst_n = 1'b0;
      bus.winc = 1'b0; bus.wch = 1'b0; bus.wdata = 8'h00;
      bus.rinc = 1'b0; bus.rch = 1'b0; flush = 2'b00; err_clr = 1'b0;
      mov = '0; mud = '0;
      for (int c = 0; c < NCH; c++) begin
         mwp[c] = '0; mrp[c] = '0;
      end
      repeat (3) @(negedge clk);
      // Reset state
      chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
      chk("rst_rvalid_ch", 32'(bus.rvalid_ch), 32'd0);
      chk("rst_winc", 32'(o_ram_winc), 32'd0);
      chk("rst_rinc", 32'(o_ram_rinc), 32'd0);
      chk_status();
      rst_n = 1'b1;

      // Fill ch0 with 0x11..0x1F, 0x10, then overflow
      for (int i = 0; i < 16; i++)
         cyc(1'b1, 1'b0, (i == 15) ? 8'h10 : 8'(8'h11 + i), 1'b0, 1'b0, 2'b00, 1'b0);
      cyc(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 2'b00, 1'b0);

      // Drain ch0, then underflow
      for (int i = 0; i < 16; i++)
         cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1);

      // ch1 to level 5, then 20 cycles of simultaneous write/read
      for (int i = 0; i < 5; i++)
         cyc(1'b1, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 20; i++)
         cyc(1'b1, 1'b1, 8'(8'hB0 + i), 1'b1, 1'b1, 2'b00, 1'b0);

      // Cross-channel interleave
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 1'b0, 8'(8'hC0 + i), 1'b1, 1'b1, 2'b00, 1'b0);
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 1'b1, 8'(8'hD0 + i), 1'b1, 1'b0, 2'b00, 1'b0);

      // Flush ch1 at level 3 together with a ch1 write; ch0 holds one word
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 1'b0);
      cyc(1'b1, 1'b0, 8'hE0, 1'b0, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 1'b1, 8'(8'hE8 + i), 1'b0, 1'b0, 2'b00, 1'b0);
      cyc(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 2'b10, 1'b0);

      // Thresholds: fill ch0 to full stepping through 14
      for (int i = 0; i < 15; i++)
         cyc(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0, 2'b00, 1'b0);
      // Overflow with err_clr in the same cycle: clear wins
      cyc(1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 2'b00, 1'b1);
      cyc(1'b1, 1'b0, 8'h78, 1'b0, 1'b0, 2'b00, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
      // Full-channel read+write and drain to check order after refill
      cyc(1'b1, 1'b0, 8'h7A, 1'b1, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 17; i++)
         cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
